// File: rtl/bus_pkg.sv
// Shared definitions for the data_bus send-side framer: FSM states, header layout
// and well-known source IDs.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    WAIT_ACK
  } state_t;

  localparam int unsigned HDR_LEN_LSB  = 0;
  localparam int unsigned HDR_LEN_W    = 4;
  localparam int unsigned HDR_DEST_LSB = 4;
  localparam int unsigned HDR_SRC_LSB  = 6;

  localparam logic [1:0] SRC_AES  = 2'b00;
  localparam logic [1:0] SRC_SHA  = 2'b01;
  localparam logic [1:0] SRC_CTRL = 2'b11;

  function automatic logic [7:0] make_header(input logic [1:0] src,
                                             input logic [1:0] dest,
                                             input logic [3:0] len_m1);
    logic [7:0] h;
    h = '0;
    h[HDR_SRC_LSB  +: 2]         = src;
    h[HDR_DEST_LSB +: 2]         = dest;
    h[HDR_LEN_LSB  +: HDR_LEN_W] = len_m1;
    return h;
  endfunction

endpackage

// File: rtl/bus_ack_timer.sv
// Loadable up-counter used to time the wait for a bus acknowledge; flags expiry
// when the count reaches LIMIT-1.
module bus_ack_timer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/bus_tx_framer.sv
// Frames one upstream word as header + payload bytes onto the data_bus send side,
// waits for the bus ack and retransmits on timeout up to MAX_RETRY times.
module bus_tx_framer
  import bus_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             src_id,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic [1:0]             in_dest,
  output logic                   send_valid,
  output logic [7:0]             send_data,
  input  logic                   send_ready,
  input  logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned      IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BYTES - 1);
  localparam logic [3:0]       LEN_M1    = 4'(NUM_BYTES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  state_t state, next_state;

  logic [8*NUM_BYTES-1:0] word_q;
  logic [7:0]             word_bytes [NUM_BYTES];
  logic [1:0]             dest_q;
  logic [1:0]             hdr_dest;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [2:0]             retry_q;

  logic accept, xfer, timer_expired, timeout, retry_ok;
  logic timer_clr, timer_en;

  logic       in_ready_d, busy_d, send_valid_d, done_d, err_d;
  logic [7:0] send_data_d;

  assign accept   = in_valid && in_ready;
  assign xfer     = send_valid && send_ready;
  assign timeout  = (state == WAIT_ACK) && !ack && timer_expired;
  assign retry_ok = (retry_q < RETRY_MAX);

  always_comb begin
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      word_bytes[i] = word_q[8*i +: 8];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = HDR;
      HDR:      if (xfer) next_state = PAYLOAD;
      PAYLOAD:  if (xfer && (idx_q == '0)) next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (ack) begin
          next_state = IDLE;
        end else if (timer_expired) begin
          next_state = retry_ok ? HDR : IDLE;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if ((state == HDR) && xfer) begin
      idx_d = IDX_LAST;
    end else if ((state == PAYLOAD) && xfer && (idx_q != '0)) begin
      idx_d = idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      dest_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
    end else begin
      if ((state == IDLE) && accept) begin
        word_q  <= in_data;
        dest_q  <= in_dest;
        retry_q <= '0;
      end else if (timeout && retry_ok) begin
        retry_q <= retry_q + 1'b1;
      end
      idx_q <= idx_d;
    end
  end

  // Outputs are registered, so the header is built while the word is still on
  // the input bus; dest_q only becomes valid on the same edge.
  assign hdr_dest = (state == IDLE) ? in_dest : dest_q;

  // Output logic
  always_comb begin
    in_ready_d   = (next_state == IDLE);
    busy_d       = !in_ready_d;
    send_valid_d = 1'b0;
    send_data_d  = '0;
    done_d       = (state == WAIT_ACK) && ack;
    err_d        = timeout && !retry_ok;
    case (next_state)
      HDR: begin
        send_valid_d = 1'b1;
        send_data_d  = (state == HDR) ? send_data : make_header(src_id, hdr_dest, LEN_M1);
      end
      PAYLOAD: begin
        send_valid_d = 1'b1;
        send_data_d  = word_bytes[idx_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      send_valid <= 1'b0;
      send_data  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      in_ready   <= in_ready_d;
      busy       <= busy_d;
      send_valid <= send_valid_d;
      send_data  <= send_data_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  assign timer_clr = (state == PAYLOAD) && (next_state == WAIT_ACK);
  assign timer_en  = (state == WAIT_ACK);

  bus_ack_timer #(
    .WIDTH (8),
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .load     (1'b0),
    .load_val (8'd0),
    .en       (timer_en),
    .expired  (timer_expired)
  );

endmodule

// File: tb/tb_bus_tx_framer.sv
// Self-checking bench for bus_tx_framer: directed scenarios plus randomized frames,
// compared each cycle against a frame-position reference model.
module tb_bus_tx_framer;
  import bus_pkg::*;

  localparam int NB = 4;
  localparam int TO = 15;
  localparam int MR = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      src_id = 2'b00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*NB-1:0] in_data = '0;
  logic [1:0]      in_dest = 2'b00;
  logic            send_valid;
  logic [7:0]      send_data;
  logic            send_ready = 1'b0;
  logic            ack = 1'b0;
  logic            busy, done, err;

  always #5 clk = ~clk;

  bus_tx_framer #(
    .NUM_BYTES   (NB),
    .ACK_TIMEOUT (TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_id     (src_id),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position -1 = idle, 0..NB = byte being offered,
  // NB+1 = waiting for ack.
  int         m_pos = -1;
  int         m_wait = 0;
  int         m_att = 0;
  logic [1:0] m_dest;
  logic [7:0] m_frame [NB+1];
  logic       e_ready = 0, e_busy = 0, e_valid = 0, e_done = 0, e_err = 0;
  logic [7:0] e_data = '0;
  bit         m_ok = 0;

  task automatic model_step();
    if (rst) begin
      m_pos = -1; m_att = 0; m_wait = 0;
      e_ready = 0; e_busy = 0; e_valid = 0; e_data = '0; e_done = 0; e_err = 0;
      return;
    end
    e_done = 0;
    e_err  = 0;
    if (m_pos < 0) begin
      if (in_valid && e_ready) begin
        m_dest = in_dest;
        for (int b = 0; b < NB; b++) m_frame[1+b] = in_data[8*(NB-1-b) +: 8];
        m_frame[0] = {src_id, m_dest, 4'(NB-1)};
        m_pos = 0;
        m_att = 0;
      end
    end else if (m_pos <= NB) begin
      if (send_ready) begin
        m_pos++;
        if (m_pos == NB + 1) m_wait = 0;
      end
    end else begin
      if (ack) begin
        e_done = 1;
        m_pos  = -1;
      end else if (m_wait == TO - 1) begin
        if (m_att < MR) begin
          m_att++;
          m_pos = 0;
          m_frame[0] = {src_id, m_dest, 4'(NB-1)};
        end else begin
          e_err = 1;
          m_pos = -1;
        end
      end else begin
        m_wait++;
      end
    end
    e_ready = (m_pos < 0);
    e_busy  = !e_ready;
    e_valid = (m_pos >= 0) && (m_pos <= NB);
    if (e_valid) e_data = m_frame[m_pos];
  endtask

  int         cyc = 0;
  logic [7:0] log_q [$];
  int         n_done = 0, n_err = 0, done_cyc = 0, acc_cyc = 0;
  bit         hold_pending = 0;
  logic [7:0] hold_data = '0;

  always @(posedge clk) cyc++;

  // Compare process
  always @(negedge clk) begin
    if (m_ok) begin
      check("in_ready", in_ready, e_ready);
      check("busy", busy, e_busy);
      check("send_valid", send_valid, e_valid);
      if (e_valid) check("send_data", send_data, e_data);
      check("done", done, e_done);
      check("err", err, e_err);
      if (hold_pending) check("stall_hold", {send_valid, send_data}, {1'b1, hold_data});
    end
    hold_pending = !rst && send_valid && !send_ready;
    hold_data    = send_data;
    if (!rst && send_valid && send_ready) log_q.push_back(send_data);
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err) n_err++;
    model_step();
    m_ok = 1;
  end

  bit rand_mode = 0;
  bit bp_mode = 0;

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      send_ready = ($urandom_range(0, 3) != 0);
      ack        = ($urandom_range(0, 11) == 0);
    end else if (bp_mode) begin
      #1;
      send_ready = (cyc % 3 == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [8*NB-1:0] data, input logic [1:0] dest);
    in_valid = 1'b1;
    in_data  = data;
    in_dest  = dest;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    check("accept_wait", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (in_ready && !busy) begin
        repeat (2) tick();
        return;
      end
      tick();
    end
    check("idle_wait", in_ready, 1'b1);
  endtask

  task automatic wait_log(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (log_q.size() >= n) return;
      tick();
    end
    check("byte_wait", log_q.size(), n);
  endtask

  task automatic clear_stats();
    log_q.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  task automatic check_frame(input string name, input int base, input logic [7:0] hdr,
                             input logic [31:0] data);
    logic [31:0] d;
    d = data;
    check({name, "_hdr"}, log_q[base], hdr);
    for (int b = 0; b < NB; b++) check({name, "_byte"}, log_q[base+1+b], d[8*(NB-1-b) +: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_send_valid", send_valid, 1'b0);
    check("rst_send_data", send_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // Basic frame, ack on the first wait cycle
    src_id = SRC_SHA; send_ready = 1'b1; ack = 1'b1;
    clear_stats();
    send_word(32'hDEADBEEF, 2'b11);
    wait_idle(100);
    check("basic_len", log_q.size(), 5);
    if (log_q.size() == 5) check_frame("basic", 0, 8'h73, 32'hDEADBEEF);
    check("basic_done", n_done, 1);
    check("basic_latency", done_cyc - acc_cyc, 7);

    // Backpressure 1,0,0 pattern
    bp_mode = 1;
    clear_stats();
    send_word(32'hDEADBEEF, 2'b11);
    wait_idle(200);
    bp_mode = 0;
    check("bp_len", log_q.size(), 5);
    if (log_q.size() == 5) check_frame("bp", 0, 8'h73, 32'hDEADBEEF);
    check("bp_done", n_done, 1);

    // Single retry
    send_ready = 1'b1; ack = 1'b0;
    clear_stats();
    send_word(32'h01234567, 2'b10);
    wait_log(10, 200);
    repeat (2) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_idle(200);
    check("retry_len", log_q.size(), 10);
    if (log_q.size() == 10) begin
      check_frame("retry1", 0, 8'h63, 32'h01234567);
      check_frame("retry2", 5, 8'h63, 32'h01234567);
    end
    check("retry_done", n_done, 1);
    check("retry_err", n_err, 0);

    // Retry exhaustion
    src_id = SRC_CTRL;
    clear_stats();
    send_word(32'hCAFEF00D, 2'b00);
    wait_idle(400);
    check("exh_len", log_q.size(), 20);
    if (log_q.size() == 20) check_frame("exh4", 15, 8'hC3, 32'hCAFEF00D);
    check("exh_err", n_err, 1);
    check("exh_done", n_done, 0);
    check("exh_in_ready", in_ready, 1'b1);

    // Ack on the final timeout cycle
    src_id = SRC_SHA;
    clear_stats();
    send_word(32'h0BADC0DE, 2'b01);
    wait_log(5, 200);
    repeat (14) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_idle(200);
    check("coll_len", log_q.size(), 5);
    check("coll_done", n_done, 1);
    check("coll_err", n_err, 0);

    // Stray ack in idle, then a new frame
    clear_stats();
    ack = 1'b1;
    repeat (3) tick();
    ack = 1'b0;
    send_word(32'h55AA55AA, 2'b10);
    repeat (3) tick();
    check("stray_no_early_done", n_done, 0);
    ack = 1'b1;
    wait_idle(200);
    ack = 1'b0;
    check("stray_done", n_done, 1);
    check("stray_len", log_q.size(), 5);

    // Reset after two payload bytes
    clear_stats();
    send_word(32'h99887766, 2'b11);
    wait_log(3, 100);
    rst = 1'b1; send_ready = 1'b0;
    tick();
    check("midrst_send_valid", send_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    rst = 1'b0; send_ready = 1'b1; ack = 1'b1;
    tick();
    clear_stats();
    send_word(32'h11223344, 2'b01);
    wait_idle(100);
    check("midrst_new_len", log_q.size(), 5);
    if (log_q.size() == 5) check_frame("midrst_new", 0, 8'h53, 32'h11223344);
    check("midrst_new_done", n_done, 1);
    check("midrst_new_err", n_err, 0);

    // Randomized frames
    ack = 1'b0;
    clear_stats();
    rand_mode = 1;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 2))
        0: src_id = SRC_AES;
        1: src_id = SRC_SHA;
        default: src_id = SRC_CTRL;
      endcase
      repeat ($urandom_range(0, 3)) tick();
      send_word($urandom, 2'($urandom_range(0, 3)));
      wait_idle(1000);
    end
    rand_mode = 0;
    check("rand_outcomes", n_done + n_err, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
